// File: rtl/irq_ctrl.sv
// irq_ctrl: rising-edge interrupt latch, mask, fixed-priority select and request/take/return sequencer.
// Ports:
//   clk, resetk      clock and asynchronous active-low reset
//   irq_in           raw interrupt sources, synchronous to clk
//   kernel           CPU in kernel mode; blocks new requests
//   take, eret       CPU takes the vector / retires return-from-handler
//   cfg_*            register port: 0x0 ENABLE, 0x4 PENDING (W1C), 0x8 CTRL (GIE), 0xC STATUS
//   irq_req          registered request to Control
//   irq_id, irq_vec  requested or in-service source and its handler address
module irq_ctrl #(
    parameter int          NSRC       = 4,
    parameter logic [31:0] VEC_BASE   = 32'h8000_0014,
    parameter int          VEC_STRIDE = 4
) (
    input  logic            clk,
    input  logic            resetk,
    input  logic [NSRC-1:0] irq_in,
    input  logic            kernel,
    input  logic            take,
    input  logic            eret,
    input  logic            cfg_rd,
    input  logic            cfg_wr,
    input  logic [3:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata,
    output logic            irq_req,
    output logic [2:0]      irq_id,
    output logic [31:0]     irq_vec
);
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] REQ     = 2'b01;
    localparam logic [1:0] SERVICE = 2'b10;

    logic [NSRC-1:0] en_q, en_d, pend_q, pend_d, prev_q;
    logic            gie_q, gie_d, req_q;
    logic [1:0]      st_q, st_d;
    logic [2:0]      id_q, id_d, win;
    logic [NSRC-1:0] elig, sel, w1c, tclr, rise;
    logic            wr_en, wr_pend, wr_ctrl, withdraw;

    assign wr_en   = cfg_wr && cfg_addr == 4'h0;
    assign wr_pend = cfg_wr && cfg_addr == 4'h4;
    assign wr_ctrl = cfg_wr && cfg_addr == 4'h8;

    assign rise = irq_in & ~prev_q;
    assign elig = pend_q & en_q;
    assign w1c  = wr_pend ? cfg_wdata[NSRC-1:0] : '0;
    assign tclr = (st_q == REQ && take) ? sel : '0;

    // A fresh edge beats both software clear and take clear on the same bit.
    assign pend_d = (pend_q & ~w1c & ~tclr) | rise;
    assign en_d   = wr_en ? cfg_wdata[NSRC-1:0] : en_q;
    assign gie_d  = wr_ctrl ? cfg_wdata[0] : gie_q;

    // One-hot of the frozen id avoids indexing with a wider-than-needed index.
    always_comb begin
        for (int i = 0; i < NSRC; i++) sel[i] = (id_q == 3'(i));
    end

    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) win = 3'(i);
    end

    assign withdraw = !(|(pend_q & sel)) || !(|(en_q & sel)) || !gie_q;

    always_comb begin
        st_d = st_q;
        id_d = id_q;
        case (st_q)
            IDLE: begin
                if (gie_q && !kernel && |elig) begin
                    st_d = REQ;
                    id_d = win;
                end
            end
            REQ:     st_d = take ? SERVICE : withdraw ? IDLE : REQ;
            SERVICE: st_d = eret ? IDLE : SERVICE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetk) begin
        if (!resetk) begin
            en_q   <= '0;
            pend_q <= '0;
            prev_q <= '0;
            gie_q  <= 1'b0;
            st_q   <= IDLE;
            id_q   <= '0;
            req_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            pend_q <= pend_d;
            prev_q <= irq_in;
            gie_q  <= gie_d;
            st_q   <= st_d;
            id_q   <= id_d;
            req_q  <= (st_d == REQ);
        end
    end

    assign irq_req = req_q;
    assign irq_id  = id_q;
    assign irq_vec = VEC_BASE + 32'(id_q) * 32'(VEC_STRIDE);

    assign cfg_rdata = !cfg_rd           ? '0 :
                       cfg_addr == 4'h0 ? 32'(en_q) :
                       cfg_addr == 4'h4 ? 32'(pend_q) :
                       cfg_addr == 4'h8 ? {31'b0, gie_q} :
                       cfg_addr == 4'hC ? {26'b0, st_q, 1'b0, id_q} : '0;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed test-plan sequences plus random traffic, checked every cycle against a rule-level model.
module tb_irq_ctrl;
    logic        clk = 0, resetk = 0;
    logic [3:0]  irq_in = 0, cfg_addr = 0;
    logic        kernel = 0, take = 0, eret = 0, cfg_rd = 0, cfg_wr = 0;
    logic [31:0] cfg_wdata = 0, cfg_rdata, irq_vec;
    logic        irq_req;
    logic [2:0]  irq_id;
    int          nvec = 0, nerr = 0;

    irq_ctrl dut (
        .clk(clk), .resetk(resetk), .irq_in(irq_in), .kernel(kernel), .take(take), .eret(eret),
        .cfg_rd(cfg_rd), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .irq_req(irq_req), .irq_id(irq_id), .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    bit [3:0] m_en, m_pend, m_prev;
    bit       m_gie;
    int       m_st, m_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_en = 0; m_pend = 0; m_prev = 0; m_gie = 0; m_st = 0; m_id = 0;
    endtask

    function automatic logic [31:0] m_rd();
        if (!cfg_rd) return 0;
        case (cfg_addr)
            4'h0: return {28'b0, m_en};
            4'h4: return {28'b0, m_pend};
            4'h8: return {31'b0, m_gie};
            4'hC: return 32'(m_st * 16 + m_id);
            default: return 0;
        endcase
    endfunction

    task automatic m_step();
        bit [3:0] elig = m_en & m_pend;
        bit [3:0] np = m_pend;
        int win = -1, nst = m_st;
        for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
        if (m_st == 0 && m_gie && !kernel && win >= 0) begin
            nst = 1; m_id = win;
        end else if (m_st == 1) begin
            if (take) begin
                nst = 2; np[m_id] = 0;
            end else if (!m_pend[m_id] || !m_en[m_id] || !m_gie) nst = 0;
        end else if (m_st == 2 && eret) nst = 0;
        if (cfg_wr && cfg_addr == 4'h0) m_en = cfg_wdata[3:0];
        if (cfg_wr && cfg_addr == 4'h4) np &= ~cfg_wdata[3:0];
        if (cfg_wr && cfg_addr == 4'h8) m_gie = cfg_wdata[0];
        np |= irq_in & ~m_prev;
        m_prev = irq_in; m_pend = np; m_st = nst;
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("irq_req", irq_req, m_st == 1);
        chk("irq_id", irq_id, 32'(m_id));
        chk("irq_vec", irq_vec, 32'h8000_0014 + 32'(m_id) * 4);
        chk("cfg_rdata", cfg_rdata, m_rd());
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cfg_wr = 1; cfg_addr = a; cfg_wdata = d;
        cyc();
        cfg_wr = 0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        cfg_rd = 1; cfg_addr = a; #1;
        chk(tag, cfg_rdata, exp);
        cfg_rd = 0;
    endtask

    task automatic pulse_take_eret();
        take = 1; cyc(); take = 0;
        eret = 1; cyc(); eret = 0;
    endtask

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1 resetk = 1;
        chk("rst_vec", irq_vec, 32'h8000_0014);
        cyc();
        // edge capture and held level
        wr(4'h0, 32'hF); wr(4'h8, 1);
        irq_in = 4'h4; cyc();
        rd("cap_pend", 4'h4, 32'h4);
        cyc();
        chk("cap_req", irq_req, 1); chk("cap_id", irq_id, 2); chk("cap_vec", irq_vec, 32'h8000_001C);
        repeat (3) cyc();
        pulse_take_eret();
        rd("cap_once", 4'h4, 32'h0);
        // priority, take, eret then next source
        irq_in = 4'hA; cyc(); irq_in = 4'h0; cyc();
        chk("pri_id", irq_id, 1);
        take = 1; cyc(); take = 0;
        rd("pri_pend", 4'h4, 32'h8); rd("pri_stat", 4'hC, 32'h21);
        chk("pri_req", irq_req, 0);
        eret = 1; cyc(); eret = 0;
        rd("ret_idle", 4'hC, 32'h01);
        cyc();
        chk("ret_req", irq_req, 1); chk("ret_id", irq_id, 3);
        pulse_take_eret();
        // withdrawal
        irq_in = 4'h1; cyc(); irq_in = 4'h0; cyc();
        chk("wd_req0", irq_req, 1);
        wr(4'h4, 32'h1); cyc();
        chk("wd_req", irq_req, 0); rd("wd_stat", 4'hC, 32'h0);
        // masking and kernel gating
        wr(4'h0, 0);
        irq_in = 4'h1; cyc(); irq_in = 4'h0; repeat (2) cyc();
        rd("mask_pend", 4'h4, 32'h1); chk("mask_req", irq_req, 0);
        kernel = 1; wr(4'h0, 1); repeat (2) cyc();
        chk("kern_req", irq_req, 0);
        kernel = 0; cyc();
        chk("kern_rel", irq_req, 1);
        pulse_take_eret();
        // set/clear collision on bit 2 (not enabled)
        irq_in = 4'h4; cyc(); irq_in = 4'h0; cyc();
        irq_in = 4'h4; wr(4'h4, 32'h4); irq_in = 4'h0;
        rd("coll_pend", 4'h4, 32'h4);
        // mid-service async reset
        wr(4'h0, 32'hF); cyc(); take = 1; cyc(); take = 0;
        rd("svc_stat", 4'hC, 32'h22);
        #3 resetk = 0; m_reset(); #1;
        chk("ar_req", irq_req, 0); rd("ar_stat", 4'hC, 0); rd("ar_en", 4'h0, 0); rd("ar_pend", 4'h4, 0);
        @(posedge clk); #1 resetk = 1;
        wr(4'h0, 32'hF);
        irq_in = 4'h1; cyc(); irq_in = 4'h0; repeat (2) cyc();
        rd("ar_edge", 4'h4, 32'h1); chk("ar_nogie", irq_req, 0);
        // random traffic
        wr(4'h8, 1);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom);
            kernel    = $urandom_range(0, 5) == 0;
            take      = $urandom_range(0, 2) == 0;
            eret      = $urandom_range(0, 3) == 0;
            cfg_rd    = $urandom_range(0, 1) == 1;
            cfg_wr    = $urandom_range(0, 5) == 0;
            cfg_addr  = $urandom_range(0, 4) == 0 ? 4'($urandom) : 4'($urandom_range(0, 3) * 4);
            cfg_wdata = $urandom;
            if (cfg_wr && cfg_addr == 4'h8 && $urandom_range(0, 1) == 1) cfg_wdata[0] = 1;
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
